rr_arbiter_8: RTL and testbench

Round-robin arbiter that shares one 8-way resource between 8 requesters. Selects a single winner and registers it as a 3-bit index plus enable. Also drives the one-hot grant vector: 3-to-8 decode of the index, all-zero when not enabled. Bounds hold time so no requester can starve the others.

---
 rtl/rr_arbiter_8.sv | 135 +++++++++++++
 tb/tb_rr_arbiter_8.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered index/enable/one-hot grant
// and a bounded hold time so a busy owner cannot starve the other requesters.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic       grant_en,
  output logic [2:0] grant_idx,
  output logic [7:0] grant,
  output logic       busy
);

  // state | meaning
  // IDLE  | no owner, all outputs deasserted
  // GRANT | grant_idx owns the resource, hold_cnt counts its extra cycles
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
  localparam logic [CNT_W-1:0] HOLD_SAT = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             grant_en_q, grant_en_d;
  logic [2:0]       grant_idx_q, grant_idx_d;
  logic [7:0]       grant_q, grant_d;
  logic             busy_q, busy_d;

  logic [7:0] others;
  logic [3:0] pick_req;
  logic [3:0] pick_oth;
  logic       owner_drop;
  logic       timeout;

  // Returns {found, index}; lowest rotation distance from start wins.
  function automatic logic [3:0] rr_pick(input logic [7:0] vec,
                                         input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'h0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    others     = req & ~(8'h01 << grant_idx_q);
    pick_req   = rr_pick(req, ptr_q);
    pick_oth   = rr_pick(others, ptr_q);
    owner_drop = ~req[grant_idx_q];
    timeout    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    grant_en_d  = grant_en_q;
    grant_idx_d = grant_idx_q;
    case (state_q)
      IDLE: begin
        if (pick_req[3]) begin
          state_d     = GRANT;
          grant_en_d  = 1'b1;
          grant_idx_d = pick_req[2:0];
          ptr_d       = pick_req[2:0] + 3'd1;
          hold_d      = '0;
        end
      end
      GRANT: begin
        if (owner_drop || timeout) begin
          // The owner is masked out of this search, so a forced switch can
          // never hand the grant straight back to it.
          if (pick_oth[3]) begin
            grant_idx_d = pick_oth[2:0];
            ptr_d       = pick_oth[2:0] + 3'd1;
            hold_d      = '0;
          end else if (owner_drop) begin
            state_d     = IDLE;
            grant_en_d  = 1'b0;
            grant_idx_d = 3'd0;
            hold_d      = '0;
          end else begin
            hold_d = '0;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_en_d  = 1'b0;
        grant_idx_d = 3'd0;
        hold_d      = '0;
      end
    endcase
    grant_d = grant_en_d ? (8'h01 << grant_idx_d) : 8'h00;
    busy_d  = grant_en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      hold_q      <= '0;
      grant_en_q  <= 1'b0;
      grant_idx_q <= 3'd0;
      grant_q     <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      grant_en_q  <= grant_en_d;
      grant_idx_q <= grant_idx_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  assign grant_en  = grant_en_q;
  assign grant_idx = grant_idx_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: three instances (MAX_HOLD 16, 4, 0)
// driven by directed vectors; a negedge monitor pops and compares expectations.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_a, req_b, req_c;
  logic       en_a, en_b, en_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic [7:0] gnt_a, gnt_b, gnt_c;
  logic       busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic       en;
    logic [2:0] idx;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  rr_arbiter_8 #(.MAX_HOLD(16), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .grant_en(en_a), .grant_idx(idx_a), .grant(gnt_a), .busy(busy_a));

  rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .grant_en(en_b), .grant_idx(idx_b), .grant(gnt_b), .busy(busy_b));

  rr_arbiter_8 #(.MAX_HOLD(0), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c),
    .grant_en(en_c), .grant_idx(idx_c), .grant(gnt_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic compare(input string name, input int sel, input logic en,
                         input logic [2:0] idx, input int late);
    logic       a_en, a_busy;
    logic [2:0] a_idx;
    logic [7:0] a_gnt, e_gnt;
    case (sel)
      0:       begin a_en = en_a; a_idx = idx_a; a_gnt = gnt_a; a_busy = busy_a; end
      1:       begin a_en = en_b; a_idx = idx_b; a_gnt = gnt_b; a_busy = busy_b; end
      default: begin a_en = en_c; a_idx = idx_c; a_gnt = gnt_c; a_busy = busy_c; end
    endcase
    e_gnt = en ? (8'h01 << idx) : 8'h00;
    checks++;
    if (late != 0 || a_en !== en || a_idx !== idx || a_gnt !== e_gnt || a_busy !== en) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d late=%0d got en=%b idx=%0d grant=%h busy=%b want en=%b idx=%0d grant=%h busy=%b",
               name, sel, cyc, late, a_en, a_idx, a_gnt, a_busy, en, idx, e_gnt, en);
    end
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      compare(e.name, e.sel, e.en, e.idx, (e.cyc != cyc) ? 1 : 0);
    end
  end

  // Drive req now (just after an edge), expect the outputs after the next edge.
  task automatic step(input int sel, input logic [7:0] reqv, input logic en,
                      input logic [2:0] idx, input string name);
    exp_t e;
    case (sel)
      0:       req_a = reqv;
      1:       req_b = reqv;
      default: req_c = reqv;
    endcase
    e.cyc  = cyc + 1;
    e.sel  = sel;
    e.en   = en;
    e.idx  = idx;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    req_c = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    compare("reset_a", 0, 1'b0, 3'd0, 0);
    compare("reset_b", 1, 1'b0, 3'd0, 0);
    compare("reset_c", 2, 1'b0, 3'd0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) step(0, 8'h00, 1'b0, 3'd0, "idle_noreq");

    step(0, 8'h08, 1'b1, 3'd3, "single_req3");
    step(0, 8'h08, 1'b1, 3'd3, "single_hold3");
    step(0, 8'h00, 1'b0, 3'd0, "single_drop");

    // Grant idx3, then pull reset between edges.
    step(0, 8'h08, 1'b1, 3'd3, "pre_async_rst");
    #5;
    rst_n = 1'b0;
    #1;
    compare("async_rst_a", 0, 1'b0, 3'd0, 0);
    req_a = 8'h00;
    @(posedge clk);
    #1;
    compare("rst_held_a", 0, 1'b0, 3'd0, 0);
    rst_n = 1'b1;

    // Fairness: every owner holds two cycles then drops for one edge.
    step(0, 8'hFF, 1'b1, 3'd0, "fair_first");
    for (int c = 0; c < 8; c++) begin
      step(0, 8'hFF, 1'b1, 3'(c), "fair_hold");
      v = 8'hFF & ~(8'h01 << c);
      step(0, v, 1'b1, 3'((c + 1) % 8), "fair_next");
    end
    step(0, 8'h00, 1'b0, 3'd0, "fair_idle");

    // ptr is 1 here; serve idx5 so ptr becomes 6.
    step(0, 8'h20, 1'b1, 3'd5, "wrap_serve5");
    step(0, 8'h00, 1'b0, 3'd0, "wrap_idle");
    step(0, 8'h41, 1'b1, 3'd6, "wrap_win6");
    step(0, 8'h01, 1'b1, 3'd0, "wrap_then0");
    step(0, 8'h00, 1'b0, 3'd0, "wrap_done");

    for (int i = 0; i < 12; i++)
      step(1, 8'h03, 1'b1, 3'((i / 4) % 2), "hold4_alt");
    for (int i = 0; i < 10; i++)
      step(1, 8'h01, 1'b1, 3'd0, "hold4_solo");
    step(1, 8'h00, 1'b0, 3'd0, "hold4_idle");

    for (int i = 0; i < 300; i++)
      step(2, 8'h05, 1'b1, 3'd0, "unlim_hold0");
    step(2, 8'h04, 1'b1, 3'd2, "unlim_switch2");
    step(2, 8'h00, 1'b0, 3'd0, "unlim_idle");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
